// File: rtl/mem_arbiter.sv
// Module: mem_arbiter
// Shares one fixed-latency memory between the IF and MEM stages, with data priority.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       kill;
    logic       d_elig;
    logic       i_elig;

    // A requester whose ack is high this cycle is not eligible again.
    assign d_elig    = dm_req & ~dm_ack;
    assign i_elig    = if_req & ~if_ack & ~if_flush;
    assign stall_mem = d_elig;
    assign stall_if  = i_elig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            kill     <= 1'b0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_elig) begin
                        state   <= BUSY_D;
                        m_en    <= 1'b1;
                        m_we    <= dm_we;
                        m_addr  <= dm_addr;
                        m_wdata <= dm_wdata;
                        cnt     <= CNT_INIT;
                        kill    <= 1'b0;
                    end else if (i_elig) begin
                        state  <= BUSY_I;
                        m_en   <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= if_addr;
                        cnt    <= CNT_INIT;
                        kill   <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (cnt == '0) begin
                        if (!m_we) dm_rdata <= m_rdata;
                        dm_ack <= 1'b1;
                        m_en   <= 1'b0;
                        m_we   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                BUSY_I: begin
                    if (if_flush) kill <= 1'b1;
                    // A redirected fetch still finishes on the bus but is never acked.
                    if (cnt == '0) begin
                        if_rdata <= m_rdata;
                        if_ack   <= ~(kill | if_flush);
                        m_en     <= 1'b0;
                        m_we     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
